// File: rtl/bcd_to_bin_seq_if.sv
// Start/result bundle for the sequential BCD-to-binary converter.
// Master drives the request; slave returns busy, done pulse and result.
interface bcd_to_bin_seq_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_BITS   = 14
);
  logic                    start;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    busy;
  logic                    done;
  logic [BIN_BITS-1:0]     bin_out;
  logic                    err;

  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Reverse double-dabble BCD-to-binary converter: 4*NUM_DIGITS shift cycles, done 4N+1 edges after start.
// Invalid digits short-circuit to a done/err pulse one edge after start; start is ignored while busy.
module bcd_to_bin_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_BITS   = 14
) (
  input  logic              clk,
  input  logic              rst,
  bcd_to_bin_seq_if.slave   bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        s_q, s_d;
  logic [W-1:0]        a_q, a_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_pend_q, err_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [BIN_BITS-1:0] bin_q, bin_d;

  logic                start_ok;
  logic                bad_digit;
  logic [2*W-1:0]      sa_shift;
  logic [W-1:0]        s_adj;
  logic [BIN_BITS-1:0] a_fit;

  // Result width may be narrower or wider than the accumulator.
  if (BIN_BITS <= W) begin : g_trunc
    assign a_fit = a_q[BIN_BITS-1:0];
  end else begin : g_pad
    assign a_fit = {{(BIN_BITS-W){1'b0}}, a_q};
  end

  assign start_ok = bus.start && !busy_q;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    sa_shift = {s_q, a_q} >> 1;
    s_adj    = sa_shift[2*W-1:W];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_adj[4*i +: 4] >= 4'd8) s_adj[4*i +: 4] = s_adj[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    a_d        = a_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    done_d     = 1'b0;
    err_d      = err_q;
    bin_d      = bin_q;

    case (state_q)
      SHIFT: begin
        s_d   = s_adj;
        a_d   = sa_shift[W-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        err_d   = err_pend_q;
        bin_d   = err_pend_q ? '0 : a_fit;
        state_d = IDLE;
      end
      default: ;
    endcase

    // A start in the DONE cycle overrides the return to IDLE but keeps the result load above.
    if (start_ok) begin
      s_d        = bus.bcd_in;
      a_d        = '0;
      cnt_d      = '0;
      err_pend_d = bad_digit;
      state_d    = bad_digit ? DONE : SHIFT;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      a_q        <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bin_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bin_q      <= bin_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Table-driven and scenario checks of bcd_to_bin_seq with a result scoreboard.
module tb_bcd_to_bin_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bcd_to_bin_seq_if #(.NUM_DIGITS(4), .BIN_BITS(14)) bus ();

  bcd_to_bin_seq #(.NUM_DIGITS(4), .BIN_BITS(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          e0;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation, including its latency.
  always @(posedge clk) begin
    #1;
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("bin_out", 32'(bus.bin_out), 32'(e.bin));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("latency", 32'(cyc - e.e0), 32'(e.lat));
      end
    end
  end

  // Called in the post-edge phase; returns in the post-edge phase just after the accepting edge.
  task automatic issue(input logic [15:0] bcd, input logic [13:0] eb, input logic ee);
    int n = 0;
    exp_t e;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (bus.busy !== 1'b0) chk("busy_wait", 32'(bus.busy), 32'd0);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(posedge clk); #1;
    e.bin = eb; e.err = ee; e.e0 = cyc; e.lat = ee ? 1 : 17;
    sbq.push_back(e);
    bus.start  = 1'b0;
    bus.bcd_in = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("pending_results", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h9999, 14'd9999, 1'b0};
    tbl[1]  = '{16'h1234, 14'd1234, 1'b0};
    tbl[2]  = '{16'h0000, 14'd0,    1'b0};
    tbl[3]  = '{16'h12A4, 14'd0,    1'b1};
    tbl[4]  = '{16'h0042, 14'd42,   1'b0};
    tbl[5]  = '{16'h000F, 14'd0,    1'b1};
    tbl[6]  = '{16'h0507, 14'd507,  1'b0};
    tbl[7]  = '{16'hF000, 14'd0,    1'b1};
    tbl[8]  = '{16'h5000, 14'd5000, 1'b0};
    tbl[9]  = '{16'h0001, 14'd1,    1'b0};
    tbl[10] = '{16'h0808, 14'd808,  1'b0};
    tbl[11] = '{16'h9090, 14'd9090, 1'b0};

    bus.start  = 1'b0;
    bus.bcd_in = 16'h0000;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_bin", 32'(bus.bin_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].bcd, tbl[i].bin, tbl[i].err);
      wait_idle(40);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("hold_bin", 32'(bus.bin_out), 32'd9090);
    chk("hold_err", 32'(bus.err), 32'd0);

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(16'h1234, 14'd1234, 1'b0);
    issue(16'h0000, 14'd0, 1'b0);
    wait_idle(60);
    issue(16'h12A4, 14'd0, 1'b1);
    issue(16'h0042, 14'd42, 1'b0);
    wait_idle(60);

    // Starts with different data at E3 and E10 must be ignored.
    issue(16'h0507, 14'd507, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.bcd_in = 16'h9999;
    @(posedge clk); #1;
    chk("busy_mid", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.bcd_in = 16'h0001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(40);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_after", 32'(bus.busy), 32'd0);

    // Reset sampled at E8 aborts the conversion silently.
    issue(16'h0042, 14'd42, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    chk("abort_bin", 32'(bus.bin_out), 32'd0);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_bin_later", 32'(bus.bin_out), 32'd0);
    issue(16'h0507, 14'd507, 1'b0);
    wait_idle(40);

    // Start held high: accepted at E0, E17, E34.
    begin
      exp_t e;
      int   c;
      c = cyc;
      e.bin = 14'd1; e.err = 1'b0; e.lat = 17;
      e.e0 = c + 1;  sbq.push_back(e);
      e.e0 = c + 18; sbq.push_back(e);
      e.e0 = c + 35; sbq.push_back(e);
      bus.start  = 1'b1;
      bus.bcd_in = 16'h0001;
      repeat (40) @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_idle(40);
    end
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
